// File: rtl/bram_port_pkg.sv
// Shared types for the BRAM stream port: controller states and the
// response record carried through the skid FIFO.
package bram_port_pkg;

    localparam int unsigned PKG_DATA_WIDTH = 32;
    localparam int unsigned PKG_TAG_WIDTH  = 4;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    typedef struct packed {
        logic [PKG_DATA_WIDTH-1:0] data;
        logic [PKG_TAG_WIDTH-1:0]  tag;
    } resp_entry_t;

endpackage

// File: rtl/bram_stream_port_if.sv
// Client request/response channels plus the RAM-side port of bram_stream_port.
// slave is the port block's view; master is the client + RAM view.
interface bram_stream_port_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned AW         = 10,
    parameter int unsigned TAG_WIDTH  = 4
);
    logic                  init_done;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [AW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [AW-1:0]         rd_addr;
    logic [TAG_WIDTH-1:0]  rd_tag;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [TAG_WIDTH-1:0]  resp_tag;
    logic                  ram_we;
    logic [AW-1:0]         ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport slave (
        output init_done, wr_ready, rd_ready, resp_valid, resp_data, resp_tag,
               ram_we, ram_addr, ram_din,
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rd_tag,
               resp_ready, ram_dout
    );

    modport master (
        input  init_done, wr_ready, rd_ready, resp_valid, resp_data, resp_tag,
               ram_we, ram_addr, ram_din,
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rd_tag,
               resp_ready, ram_dout
    );

endinterface

// File: rtl/bram_resp_fifo.sv
// Circular response FIFO; the caller guarantees no push when full.
// A pop on an empty FIFO is ignored.
module bram_resp_fifo
    import bram_port_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter type         entry_t = resp_entry_t
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  entry_t                       din,
    output entry_t                       dout,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_pop;

    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bram_stream_port.sv
// Initiator for one port of a 1-cycle-latency RAM: clears the array after
// reset, then serves write and tagged read channels with a skid FIFO.
module bram_stream_port
    import bram_port_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = PKG_DATA_WIDTH,
    parameter int unsigned           SIZE       = 1024,
    parameter int unsigned           TAG_WIDTH  = PKG_TAG_WIDTH,
    parameter int unsigned           BUF_DEPTH  = 3,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    bram_stream_port_if.slave   bus
);

    localparam int unsigned AW = $clog2(SIZE);
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  tag;
    } entry_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         cnt_q;
    logic [AW-1:0]         last_addr_q;
    logic                  inflight_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic                  sweep_last;
    logic                  credit_ok;
    logic                  rd_ok;
    logic                  rd_fire;
    logic [CW-1:0]         fifo_cnt;
    logic                  fifo_empty;
    entry_t                fifo_din;
    entry_t                fifo_dout;

    assign sweep_last = (cnt_q == AW'(SIZE - 1));

    // Credits count both buffered entries and the read still in the RAM pipe,
    // so every accepted read has a guaranteed FIFO slot when its data lands.
    assign credit_ok = ({1'b0, fifo_cnt} + (CW+1)'(inflight_q)) < (CW+1)'(BUF_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            last_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            last_addr_q <= bus.ram_addr;
            if (state_q == ST_INIT) begin
                cnt_q <= sweep_last ? '0 : cnt_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            inflight_q <= rd_fire;
            if (rd_fire) begin
                tag_q <= bus.rd_tag;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = last_addr_q;
        bus.ram_din   = bus.wr_data;
        bus.wr_ready  = 1'b0;
        bus.rd_ready  = 1'b0;
        bus.init_done = 1'b0;
        rd_ok         = 1'b0;
        rd_fire       = 1'b0;
        case (state_q)
            ST_INIT: begin
                bus.ram_we   = 1'b1;
                bus.ram_addr = cnt_q;
                bus.ram_din  = INIT_VALUE;
                if (sweep_last) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                bus.init_done = 1'b1;
                bus.wr_ready  = 1'b1;
                rd_ok         = !bus.wr_valid && credit_ok;
                bus.rd_ready  = rd_ok;
                rd_fire       = bus.rd_valid && rd_ok;
                if (bus.wr_valid) begin
                    bus.ram_we   = 1'b1;
                    bus.ram_addr = bus.wr_addr;
                end else if (rd_fire) begin
                    bus.ram_addr = bus.rd_addr;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign fifo_din.data = bus.ram_dout;
    assign fifo_din.tag  = tag_q;

    bram_resp_fifo #(
        .DEPTH   (BUF_DEPTH),
        .entry_t (entry_t)
    ) u_resp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .pop   (bus.resp_valid && bus.resp_ready),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign bus.resp_valid = !fifo_empty;
    assign bus.resp_data  = fifo_dout.data;
    assign bus.resp_tag   = fifo_dout.tag;

endmodule

// File: tb/tb_bram_stream_port.sv
// Bench for bram_stream_port with a behavioural RAM and a transaction-level
// scoreboard (memory image + queue of outstanding responses).
module tb_bram_stream_port;

    localparam int unsigned DW   = 32;
    localparam int unsigned SIZE = 16;
    localparam int unsigned TW   = 4;
    localparam int unsigned BUFD = 3;
    localparam int unsigned AW   = $clog2(SIZE);
    localparam logic [DW-1:0] INITV = '0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_stream_port_if #(.DATA_WIDTH(DW), .AW(AW), .TAG_WIDTH(TW)) bus ();

    bram_stream_port #(
        .DATA_WIDTH (DW),
        .SIZE       (SIZE),
        .TAG_WIDTH  (TW),
        .BUF_DEPTH  (BUFD),
        .INIT_VALUE (INITV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM with 1-cycle read latency, write_first, no content reset
    logic [DW-1:0] ram [SIZE];
    initial for (int i = 0; i < SIZE; i++) ram[i] = 32'hA5A5_0000 + i;
    always @(posedge clk) begin
        if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= bus.ram_we ? bus.ram_din : ram[bus.ram_addr];
    end

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [SIZE];
    int cyc, tests, fails;
    bit last_wr_fire, last_rd_fire, last_resp_fire;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock: check outputs for the current inputs, advance the model on
    // the handshakes that will happen at the coming edge, then step.
    task automatic cycle();
        bit run, erv, erd;
        #1;
        run = (cyc >= SIZE);
        erd = run && !bus.wr_valid && (exp_q.size() < BUFD);
        erv = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        check("init_done", bus.init_done, run);
        check("wr_ready", bus.wr_ready, run);
        check("rd_ready", bus.rd_ready, erd);
        check("resp_valid", bus.resp_valid, erv);
        if (erv && bus.resp_valid) begin
            check("resp_data", bus.resp_data, exp_q[0].data);
            check("resp_tag", bus.resp_tag, exp_q[0].tag);
        end
        if (!run) begin
            check("sweep_we", bus.ram_we, 1);
            check("sweep_addr", bus.ram_addr, cyc);
            check("sweep_din", bus.ram_din, INITV);
        end else if (bus.wr_valid) begin
            check("wr_we", bus.ram_we, 1);
            check("wr_addr", bus.ram_addr, bus.wr_addr);
            check("wr_din", bus.ram_din, bus.wr_data);
        end else begin
            check("rd_we", bus.ram_we, 0);
            if (erd && bus.rd_valid) check("rd_addr", bus.ram_addr, bus.rd_addr);
        end
        last_resp_fire = bus.resp_valid && bus.resp_ready;
        last_wr_fire   = bus.wr_valid && bus.wr_ready;
        last_rd_fire   = bus.rd_valid && bus.rd_ready;
        if (last_resp_fire && exp_q.size() > 0) void'(exp_q.pop_front());
        if (last_wr_fire) ref_mem[bus.wr_addr] = bus.wr_data;
        if (last_rd_fire) exp_q.push_back('{ref_mem[bus.rd_addr], bus.rd_tag, cyc + 2});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_valid = 0; bus.rd_addr = '0; bus.rd_tag = '0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        exp_q.delete();
        for (int i = 0; i < SIZE; i++) ref_mem[i] = INITV;
    endtask

    typedef struct {
        bit            wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        bit            rv;
        logic [AW-1:0] ra;
        logic [TW-1:0] rt;
        bit            e_rd_ready;
        bit            e_resp_valid;
        logic [DW-1:0] e_data;
        logic [TW-1:0] e_tag;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int acc, nxt, got, first, last;
        bit wp, rp;
        vecs[0]  = '{0, 0, 0,            1, 5, 3, 1, 0, 0,            0};
        vecs[1]  = '{0, 0, 0,            0, 0, 0, 1, 0, 0,            0};
        vecs[2]  = '{0, 0, 0,            0, 0, 0, 1, 1, 0,            3};
        vecs[3]  = '{1, 7, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0,            0};
        vecs[4]  = '{0, 0, 0,            1, 7, 1, 1, 0, 0,            0};
        vecs[5]  = '{0, 0, 0,            0, 0, 0, 1, 0, 0,            0};
        vecs[6]  = '{0, 0, 0,            0, 0, 0, 1, 1, 32'hDEADBEEF, 1};
        vecs[7]  = '{1, 2, 32'h11,       1, 9, 5, 0, 0, 0,            0};
        vecs[8]  = '{0, 0, 0,            1, 9, 5, 1, 0, 0,            0};
        vecs[9]  = '{0, 0, 0,            0, 0, 0, 1, 0, 0,            0};
        vecs[10] = '{0, 0, 0,            0, 0, 0, 1, 1, 0,            5};
        vecs[11] = '{0, 0, 0,            1, 2, 6, 1, 0, 0,            0};
        vecs[12] = '{0, 0, 0,            0, 0, 0, 1, 0, 0,            0};
        vecs[13] = '{0, 0, 0,            0, 0, 0, 1, 1, 32'h11,       6};

        tests = 0; fails = 0; cyc = 0;
        idle_inputs();
        bus.resp_ready = 1;
        #1;
        check("reset_resp_valid", bus.resp_valid, 0);
        check("reset_rd_ready", bus.rd_ready, 0);
        check("reset_wr_ready", bus.wr_ready, 0);
        check("reset_init_done", bus.init_done, 0);
        repeat (3) @(posedge clk);
        release_reset();

        // Sweep: ready low, addresses 0..SIZE-1; init_done appears at cycle SIZE
        bus.wr_valid = 1; bus.rd_valid = 1;
        for (int i = 0; i < SIZE; i++) cycle();
        idle_inputs();
        #1;
        check("init_done_at_size", bus.init_done, 1);

        foreach (vecs[i]) begin
            bus.wr_valid = vecs[i].wv; bus.wr_addr = vecs[i].wa; bus.wr_data = vecs[i].wd;
            bus.rd_valid = vecs[i].rv; bus.rd_addr = vecs[i].ra; bus.rd_tag = vecs[i].rt;
            #1;
            check("vec_rd_ready", bus.rd_ready, vecs[i].e_rd_ready);
            check("vec_resp_valid", bus.resp_valid, vecs[i].e_resp_valid);
            if (vecs[i].e_resp_valid) begin
                check("vec_resp_data", bus.resp_data, vecs[i].e_data);
                check("vec_resp_tag", bus.resp_tag, vecs[i].e_tag);
            end
            cycle();
        end
        idle_inputs();

        // Backpressure: only BUF_DEPTH reads may be outstanding
        bus.resp_ready = 0;
        acc = 0; nxt = 0;
        for (int c = 0; c < 6; c++) begin
            bus.rd_valid = 1; bus.rd_addr = AW'(nxt); bus.rd_tag = TW'(nxt);
            cycle();
            if (last_rd_fire) begin acc++; nxt++; end
        end
        check("bp_accepts", acc, BUFD);
        #1;
        check("bp_rd_ready_stalled", bus.rd_ready, 0);
        bus.resp_ready = 1;
        got = 0; first = -1; last = -1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            bus.rd_valid = (nxt < 8);
            bus.rd_addr = AW'(nxt); bus.rd_tag = TW'(nxt);
            cycle();
            if (last_rd_fire) nxt++;
            if (last_resp_fire) begin
                got++;
                if (first < 0) first = c;
                last = c;
            end
        end
        check("bp_responses", got, 8);
        check("bp_sustained", last - first, 7);
        idle_inputs();

        // Random traffic with valids held until accepted
        wp = 0; rp = 0;
        for (int c = 0; c < 400; c++) begin
            if (!wp && ($urandom % 3 == 0)) begin
                wp = 1; bus.wr_addr = AW'($urandom); bus.wr_data = $urandom;
            end
            if (!rp && ($urandom % 2 == 0)) begin
                rp = 1; bus.rd_addr = AW'($urandom); bus.rd_tag = TW'($urandom);
            end
            bus.wr_valid = wp; bus.rd_valid = rp;
            bus.resp_ready = ($urandom % 4 != 0);
            cycle();
            if (last_wr_fire) wp = 0;
            if (last_rd_fire) rp = 0;
        end
        idle_inputs();
        bus.resp_ready = 1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) cycle();
        check("drain_empty", exp_q.size(), 0);

        // Reset with responses buffered: output drops at once, sweep restarts
        bus.resp_ready = 0;
        bus.rd_valid = 1; bus.rd_addr = 3; bus.rd_tag = 9;
        cycle();
        bus.rd_addr = 4; bus.rd_tag = 10;
        cycle();
        idle_inputs();
        repeat (3) cycle();
        check("pre_reset_buffered", bus.resp_valid, 1);
        rst_n = 1'b0;
        #1;
        check("reset_drops_resp_valid", bus.resp_valid, 0);
        check("reset_sweep_addr0", bus.ram_addr, 0);
        check("reset_sweep_we", bus.ram_we, 1);
        repeat (2) @(posedge clk);
        release_reset();
        bus.resp_ready = 1;
        for (int i = 0; i < SIZE + 6; i++) cycle();
        check("no_stale_resp", bus.resp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
